sync_fifo: RTL and testbench

Parametrised single-clock synchronous FIFO in portable RTL. It is the successor to the vendor-megafunction FIFO wrapper. It adds configurable depth and width, a selectable normal or show-ahead read mode, a fill level output, programmable almost-full and almost-empty flags, and registered overflow/underflow error pulses. It sits between producer and consumer stages on the common `clock` domain. Storage is an inferred memory with a registered read path.

---
 rtl/sync_fifo.sv | 98 +++++++++
 tb/tb_sync_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO, normal or show-ahead read, level flags
// Revision  : 1.0
// ============================================================================
module sync_fifo #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 4,
  parameter bit SHOWAHEAD          = 1'b0,
  parameter int ALMOST_FULL_LEVEL  = (2 ** ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wrreq,
  output logic                  full,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_W    = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_W    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr_nxt;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full         = (usedw == DEPTH_W);
  assign empty        = (usedw == '0);
  assign almost_full  = (usedw >= AF_W);
  assign almost_empty = (usedw < AE_W);

  assign wr_ok      = wrreq & ~full;
  assign rd_ok      = rdreq & ~empty;
  assign rd_ptr_nxt = rd_ptr + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      usedw     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr_nxt;
      case ({wr_ok, rd_ok})
        2'b10:   usedw <= usedw + ONE_W;
        2'b01:   usedw <= usedw - ONE_W;
        default: usedw <= usedw;
      endcase
      overflow  <= wrreq & full;
      underflow <= rdreq & empty;
    end
  end

  // Storage is left uninitialised; reset only discards it via the pointers.
  always_ff @(posedge clock) begin
    if (wr_ok && !reset) mem[wr_ptr] <= data;
  end

  generate
    if (SHOWAHEAD) begin : g_showahead
      // q always holds the head; on a pop it prefetches the next entry, or
      // takes the incoming word directly when that word becomes the head.
      always_ff @(posedge clock) begin
        if (reset) begin
          q <= '0;
        end else if (rd_ok) begin
          if (usedw > ONE_W)  q <= mem[rd_ptr_nxt];
          else if (wr_ok)     q <= data;
        end else if (empty && wr_ok) begin
          q <= data;
        end
      end
    end else begin : g_normal
      always_ff @(posedge clock) begin
        if (reset)      q <= '0;
        else if (rd_ok) q <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// tb_sync_fifo : directed checks on normal and show-ahead FIFOs, plus soak
// Revision     : 1.0
// ============================================================================
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       wrreq;
  logic       rdreq;

  logic       n_full, n_empty, n_af, n_ae, n_ovf, n_udf;
  logic [7:0] n_q;
  logic [2:0] n_usedw;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [7:0] s_q;
  logic [2:0] s_usedw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .SHOWAHEAD(1'b0)) u_norm (
    .clock(clk), .reset(rst), .data(data), .wrreq(wrreq), .full(n_full),
    .rdreq(rdreq), .q(n_q), .empty(n_empty), .usedw(n_usedw),
    .almost_full(n_af), .almost_empty(n_ae), .overflow(n_ovf), .underflow(n_udf)
  );

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .SHOWAHEAD(1'b1)) u_sa (
    .clock(clk), .reset(rst), .data(data), .wrreq(wrreq), .full(s_full),
    .rdreq(rdreq), .q(s_q), .empty(s_empty), .usedw(s_usedw),
    .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_udf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample #1 after the edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    wrreq = w; rdreq = r; data = d;
    @(posedge clk);
    #1;
  endtask

  // Level-derived outputs of both DUTs for an expected fill level.
  task automatic chk_lvl(input string tag, input int u);
    check({tag, " n_usedw"}, n_usedw, u);
    check({tag, " s_usedw"}, s_usedw, u);
    check({tag, " full"},  {n_full, s_full},   (u == 4) ? 2'b11 : 2'b00);
    check({tag, " empty"}, {n_empty, s_empty}, (u == 0) ? 2'b11 : 2'b00);
    check({tag, " af"},    {n_af, s_af},       (u >= 2) ? 2'b11 : 2'b00);
    check({tag, " ae"},    {n_ae, s_ae},       (u < 2)  ? 2'b11 : 2'b00);
  endtask

  task automatic chk_err(input string tag, input logic ovf, input logic udf);
    check({tag, " ovf"}, {n_ovf, s_ovf}, {ovf, ovf});
    check({tag, " udf"}, {n_udf, s_udf}, {udf, udf});
  endtask

  logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] mq [$];
  logic [7:0] n_exp, s_exp;
  logic       ovf_exp, udf_exp;

  initial begin
    rst = 1'b1; wrreq = 1'b0; rdreq = 1'b0; data = '0;
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'hEE);
    rst = 1'b0;
    chk_lvl("reset", 0);
    chk_err("reset", 1'b0, 1'b0);
    check("reset n_q", n_q, 8'h00);
    check("reset s_q", s_q, 8'h00);

    // Fill 0x11..0x44
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, vals[i]);
      chk_lvl($sformatf("fill%0d", i), i + 1);
      check("fill s_q head", s_q, 8'h11);
    end
    cyc(1'b1, 1'b0, 8'h55);
    chk_lvl("ovf", 4);
    chk_err("ovf pulse", 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00);
    chk_err("ovf clear", 1'b0, 1'b0);

    // Drain with one underflowing read
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk_lvl($sformatf("drain%0d", i), 3 - i);
      check($sformatf("drain%0d n_q", i), n_q, vals[i]);
      check($sformatf("drain%0d s_q", i), s_q, (i < 3) ? vals[i + 1] : 8'h44);
    end
    cyc(1'b0, 1'b1, 8'h00);
    chk_err("udf pulse", 1'b0, 1'b1);
    check("udf n_q hold", n_q, 8'h44);
    check("udf s_q hold", s_q, 8'h44);
    cyc(1'b0, 1'b0, 8'h00);
    chk_err("udf clear", 1'b0, 1'b0);

    // Show-ahead fall-through
    cyc(1'b1, 1'b0, 8'hA5);
    chk_lvl("fwft", 1);
    check("fwft s_q", s_q, 8'hA5);
    check("fwft n_q hold", n_q, 8'h44);
    cyc(1'b0, 1'b1, 8'h00);
    chk_lvl("fwft pop", 0);
    check("fwft pop s_q", s_q, 8'hA5);
    check("fwft pop n_q", n_q, 8'hA5);

    // Simultaneous on full
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 8'(i));
    chk_lvl("refill", 4);
    cyc(1'b1, 1'b1, 8'h99);
    chk_lvl("full rw", 3);
    chk_err("full rw", 1'b1, 1'b0);
    check("full rw n_q", n_q, 8'h01);
    check("full rw s_q", s_q, 8'h02);
    for (int i = 2; i <= 4; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      check("full rw drain n_q", n_q, 8'(i));
    end
    chk_lvl("full rw drained", 0);

    // Simultaneous on empty
    cyc(1'b1, 1'b1, 8'h66);
    chk_lvl("empty rw", 1);
    chk_err("empty rw", 1'b0, 1'b1);
    check("empty rw s_q", s_q, 8'h66);
    check("empty rw n_q", n_q, 8'h04);
    cyc(1'b0, 1'b1, 8'h00);
    check("empty rw read n_q", n_q, 8'h66);
    chk_lvl("empty rw read", 0);

    // Half full streaming across pointer wrap
    cyc(1'b1, 1'b0, 8'h80);
    cyc(1'b1, 1'b0, 8'h81);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 8'(8'h82 + i));
      chk_lvl("stream", 2);
      check($sformatf("stream%0d n_q", i), n_q, 8'(8'h80 + i));
      check($sformatf("stream%0d s_q", i), s_q, 8'(8'h81 + i));
    end
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    check("stream tail n_q", n_q, 8'h8B);
    chk_lvl("stream drained", 0);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
    rst = 1'b1;
    cyc(1'b1, 1'b1, 8'hDD);
    rst = 1'b0;
    chk_lvl("mid reset", 0);
    chk_err("mid reset", 1'b0, 1'b0);
    check("mid reset n_q", n_q, 8'h00);
    check("mid reset s_q", s_q, 8'h00);
    cyc(1'b1, 1'b0, 8'h77);
    check("post reset s_q", s_q, 8'h77);
    cyc(1'b0, 1'b1, 8'h00);
    check("post reset n_q", n_q, 8'h77);
    chk_lvl("post reset", 0);

    // Soak against a queue model
    rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    mq.delete();
    n_exp = '0; s_exp = '0;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 750; c++) begin
        logic w, r;
        logic [7:0] d;
        int wp, rp;
        wp = (p == 0) ? 70 : (p == 1) ? 30 : (p == 2) ? 50 : 90;
        rp = (p == 0) ? 30 : (p == 1) ? 70 : (p == 2) ? 50 : 90;
        w = ($urandom_range(0, 99) < wp);
        r = ($urandom_range(0, 99) < rp);
        d = 8'($urandom_range(0, 255));
        ovf_exp = w && (mq.size() == 4);
        udf_exp = r && (mq.size() == 0);
        if (r && mq.size() != 0) n_exp = mq.pop_front();
        if (w && !ovf_exp) mq.push_back(d);
        if (mq.size() != 0) s_exp = mq[0];
        cyc(w, r, d);
        chk_lvl("soak", mq.size());
        chk_err("soak", ovf_exp, udf_exp);
        check("soak n_q", n_q, n_exp);
        check("soak s_q", s_q, s_exp);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
